// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared state type and port constants for the round-robin output arbiter
package arbiter_pkg;
   typedef enum logic {IDLE, SERVE} arb_state_t;
   localparam int ARB_N_PORTS = 5;
   localparam int PORT_L = 0;
   localparam int PORT_N = 1;
   localparam int PORT_E = 2;
   localparam int PORT_W = 3;
   localparam int PORT_S = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request bit scanning circularly upwards from start
module rr_pick #(
   parameter int N  = 5,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic          valid,
   output logic [IW-1:0] idx
);
   always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(start) + k) % N]) idx = IW'((int'(start) + k) % N);
   end
   assign valid = |req;
endmodule

// File: rtl/arbiter_rr.sv
// arbiter_rr: round-robin output-port arbiter with RTS/DCTS handshake; ARB_HOLD_LIMIT_EN adds a per-owner burst limit
module arbiter_rr
   import arbiter_pkg::*;
#(
   parameter int N_PORTS  = ARB_N_PORTS,
   parameter int IDX_W    = $clog2(N_PORTS),
   parameter int MAX_HOLD = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_PORTS-1:0] req,
   input  logic               dcts,
   output logic [N_PORTS-1:0] grant,
   output logic [N_PORTS-1:0] xbar_sel,
   output logic               rts,
   output logic [IDX_W-1:0]   owner
);
   arb_state_t         state, state_d;
   logic [IDX_W-1:0]   owner_d, ptr, ptr_d, owner_inc, start, pick_idx;
   logic               rts_d, pick_valid, xfer, limit;
   logic [N_PORTS-1:0] owner_oh;

   assign owner_inc = (owner == IDX_W'(N_PORTS - 1)) ? '0 : owner + 1'b1;
   assign start     = (state == IDLE) ? ptr : owner_inc;
   assign owner_oh  = N_PORTS'(1) << owner;
   assign xfer      = (state == SERVE) && rts && dcts;
   assign grant     = xfer ? owner_oh : '0;
   assign xbar_sel  = (state == SERVE) ? owner_oh : '0;

   rr_pick #(.N(N_PORTS), .IW(IDX_W)) u_pick (
      .req   (req),
      .start (start),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
   // the counter saturates, so a long burst yields at its next grant once anyone else asks
   assign limit      = xfer && (hold_cnt == HOLD_W'(MAX_HOLD - 1)) && |(req & ~owner_oh);
   assign hold_cnt_d = (state_d != SERVE || owner_d != owner) ? '0 :
                       (xfer && hold_cnt != HOLD_W'(MAX_HOLD - 1)) ? hold_cnt + 1'b1 : hold_cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) hold_cnt <= '0;
      else      hold_cnt <= hold_cnt_d;
`else
   assign limit = 1'b0;
`endif

   always_comb begin
      state_d = state;
      owner_d = owner;
      ptr_d   = ptr;
      rts_d   = rts;
      if (state == IDLE) begin
         rts_d = 1'b0;
         if (pick_valid) begin
            state_d = SERVE;
            owner_d = pick_idx;
         end
      end else if (!(rts && !dcts)) begin
         rts_d = !xfer;
         if (!req[owner] || limit) begin
            ptr_d   = owner_inc;
            state_d = pick_valid ? SERVE : IDLE;
            owner_d = pick_valid ? pick_idx : '0;
            rts_d   = pick_valid && !xfer;
         end
      end
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         owner <= '0;
         ptr   <= '0;
         rts   <= 1'b0;
      end else begin
         state <= state_d;
         owner <= owner_d;
         ptr   <= ptr_d;
         rts   <= rts_d;
      end
endmodule
